// File: rtl/asym_fifo_ctrl_pkg.sv
// Shared constants and sizing helpers for the asymmetric-width FIFO controller.
// Pure compile-time content: no latency, no flow control.
package asym_fifo_pkg;

  localparam bit WIDE_SIDE_WR = 1'b1;
  localparam bit WIDE_SIDE_RD = 1'b0;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ratio_of(input int ratio_log2);
    return 1 << ratio_log2;
  endfunction

  // Pointer step (log2, narrow units) of the write side.
  function automatic int wr_step_log2(input bit wide_wr, input int ratio_log2);
    return (wide_wr == WIDE_SIDE_WR) ? ratio_log2 : 0;
  endfunction

  // Pointer step (log2, narrow units) of the read side.
  function automatic int rd_step_log2(input bit wide_wr, input int ratio_log2);
    return (wide_wr == WIDE_SIDE_RD) ? ratio_log2 : 0;
  endfunction

endpackage

// File: rtl/asym_fifo_ctrl_if.sv
// Producer/consumer request and status bundle of the asymmetric FIFO controller.
// Address widths follow the wide/narrow orientation selected by WIDE_WR.
interface asym_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int RATIO_LOG2 = 1,
  parameter bit WIDE_WR    = 1'b1
);
  localparam int W_ADDR_W = WIDE_WR ? (ADDR_WIDTH - RATIO_LOG2) : ADDR_WIDTH;
  localparam int R_ADDR_W = WIDE_WR ? ADDR_WIDTH : (ADDR_WIDTH - RATIO_LOG2);

  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic [W_ADDR_W-1:0]   w_addr;
  logic [R_ADDR_W-1:0]   r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, clr_err,
    input  w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/asym_fifo_ctrl_fifo_ptr.sv
// Wrapping FIFO pointer in narrow units that advances by 2^STEP_LOG2 when step_en is high.
// One-cycle update; no flow control of its own, the caller gates step_en.
module fifo_ptr #(
  parameter int PTR_WIDTH = 4,
  parameter int STEP_LOG2 = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step_en,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] STEP = PTR_WIDTH'(1) << STEP_LOG2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (step_en) begin
      ptr <= ptr + STEP;
    end
  end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Pointer/status controller for an asymmetric-width FIFO; all outputs derive from registered pointers (1-cycle update).
// Requests are refused (not queued) when full/empty; sticky overflow/underflow exist only with ASYM_FIFO_ERR_EN.
module asym_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int RATIO_LOG2 = 1,
  parameter bit WIDE_WR    = WIDE_SIDE_WR,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - (1 << RATIO_LOG2),
  parameter int AE_LEVEL   = (1 << RATIO_LOG2)
) (
  input  logic             clk,
  input  logic             reset_n,
  asym_fifo_ctrl_if.slave  bus
);

  localparam int D            = depth_of(ADDR_WIDTH);
  localparam int R            = ratio_of(RATIO_LOG2);
  localparam int PW           = ADDR_WIDTH + 1;
  localparam int WR_STEP_LOG2 = wr_step_log2(WIDE_WR, RATIO_LOG2);
  localparam int RD_STEP_LOG2 = rd_step_log2(WIDE_WR, RATIO_LOG2);

  localparam logic [PW-1:0] DEPTH_V = PW'(D);
  localparam logic [PW-1:0] RATIO_V = PW'(R);
  localparam logic [PW-1:0] AF_V    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_V    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic          full_s;
  logic          empty_s;
  logic          wr_acc;
  logic          rd_acc;

  // The wrap bit makes the modular difference span the full 0..D range.
  assign occ = wr_ptr - rd_ptr;

  generate
    if (WIDE_WR == WIDE_SIDE_WR) begin : g_wide_wr
      // A wide write needs R free narrow slots; one stored word is enough to read.
      assign full_s     = (DEPTH_V - occ) < RATIO_V;
      assign empty_s    = (occ == '0);
      assign bus.w_addr = wr_ptr[ADDR_WIDTH-1:RATIO_LOG2];
      assign bus.r_addr = rd_ptr[ADDR_WIDTH-1:0];
    end else begin : g_wide_rd
      // A wide read needs R stored narrow words; one free slot is enough to write.
      assign full_s     = (occ == DEPTH_V);
      assign empty_s    = occ < RATIO_V;
      assign bus.w_addr = wr_ptr[ADDR_WIDTH-1:0];
      assign bus.r_addr = rd_ptr[ADDR_WIDTH-1:RATIO_LOG2];
    end
  endgenerate

  assign wr_acc = bus.wr & ~full_s;
  assign rd_acc = bus.rd & ~empty_s;

  fifo_ptr #(
    .PTR_WIDTH (PW),
    .STEP_LOG2 (WR_STEP_LOG2)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .step_en (wr_acc),
    .ptr     (wr_ptr)
  );

  fifo_ptr #(
    .PTR_WIDTH (PW),
    .STEP_LOG2 (RD_STEP_LOG2)
  ) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .step_en (rd_acc),
    .ptr     (rd_ptr)
  );

  assign bus.count        = occ;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (occ >= AF_V);
  assign bus.almost_empty = (occ <= AE_V);

`ifdef ASYM_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // A refused request in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr && full_s) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.rd && empty_s) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Bench for asym_fifo_ctrl: one write-wide and one read-wide instance (D=8, R=2)
// driven by directed sequences and random traffic, compared against an occupancy model.
module tb_asym_fifo_ctrl;

  localparam int AW = 3;
  localparam int RL = 1;
  localparam int D  = 8;
  localparam int R  = 2;
`ifdef ASYM_FIFO_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] wr_i = '0;
  logic [1:0] rd_i = '0;
  logic [1:0] clr_i = '0;

  asym_fifo_ctrl_if #(.ADDR_WIDTH(AW), .RATIO_LOG2(RL), .WIDE_WR(1'b1)) bw ();
  asym_fifo_ctrl_if #(.ADDR_WIDTH(AW), .RATIO_LOG2(RL), .WIDE_WR(1'b0)) bn ();

  assign bw.wr      = wr_i[0];
  assign bw.rd      = rd_i[0];
  assign bw.clr_err = clr_i[0];
  assign bn.wr      = wr_i[1];
  assign bn.rd      = rd_i[1];
  assign bn.clr_err = clr_i[1];

  asym_fifo_ctrl #(.ADDR_WIDTH(AW), .RATIO_LOG2(RL), .WIDE_WR(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bw)
  );
  asym_fifo_ctrl #(.ADDR_WIDTH(AW), .RATIO_LOG2(RL), .WIDE_WR(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .bus(bn)
  );

  // Reference model: occupancy and positions in narrow words, index 0 = write-wide, 1 = read-wide.
  int m_cnt[2];
  int m_wp[2];
  int m_rp[2];
  int m_ovf[2];
  int m_unf[2];
  int n_checks = 0;
  int n_errors = 0;
  string phase = "reset";

  function automatic int wstep(int k);
    return (k == 0) ? R : 1;
  endfunction

  function automatic int rstep(int k);
    return (k == 0) ? 1 : R;
  endfunction

  function automatic int m_full(int k);
    return (k == 0) ? int'((D - m_cnt[k]) < R) : int'(m_cnt[k] == D);
  endfunction

  function automatic int m_empty(int k);
    return (k == 0) ? int'(m_cnt[k] == 0) : int'(m_cnt[k] < R);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int wa;
    int ra;
    wa = int'(wr_i[k]) & (1 - m_full(k));
    ra = int'(rd_i[k]) & (1 - m_empty(k));
    if (ERR_EN != 0) begin
      if (wr_i[k] && m_full(k) != 0) m_ovf[k] = 1;
      else if (clr_i[k]) m_ovf[k] = 0;
      if (rd_i[k] && m_empty(k) != 0) m_unf[k] = 1;
      else if (clr_i[k]) m_unf[k] = 0;
    end
    if (wa != 0) m_wp[k] = (m_wp[k] + wstep(k)) % (2 * D);
    if (ra != 0) m_rp[k] = (m_rp[k] + rstep(k)) % (2 * D);
    m_cnt[k] = m_cnt[k] + wa * wstep(k) - ra * rstep(k);
  endtask

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s [%s]: got %0d, expected %0d", tag, phase, got, exp);
    end
  endtask

  task automatic check_dut(int k);
    int c, f, e, af, ae, wa, ra, ov, un, exp_wa, exp_ra;
    if (k == 0) begin
      c = int'(bw.count); f = int'(bw.full); e = int'(bw.empty);
      af = int'(bw.almost_full); ae = int'(bw.almost_empty);
      wa = int'(bw.w_addr); ra = int'(bw.r_addr);
      ov = int'(bw.overflow); un = int'(bw.underflow);
      exp_wa = (m_wp[k] % D) / R; exp_ra = m_rp[k] % D;
    end else begin
      c = int'(bn.count); f = int'(bn.full); e = int'(bn.empty);
      af = int'(bn.almost_full); ae = int'(bn.almost_empty);
      wa = int'(bn.w_addr); ra = int'(bn.r_addr);
      ov = int'(bn.overflow); un = int'(bn.underflow);
      exp_wa = m_wp[k] % D; exp_ra = (m_rp[k] % D) / R;
    end
    check($sformatf("d%0d count", k), c, m_cnt[k]);
    check($sformatf("d%0d full", k), f, m_full(k));
    check($sformatf("d%0d empty", k), e, m_empty(k));
    check($sformatf("d%0d almost_full", k), af, int'(m_cnt[k] >= D - R));
    check($sformatf("d%0d almost_empty", k), ae, int'(m_cnt[k] <= R));
    check($sformatf("d%0d w_addr", k), wa, exp_wa);
    check($sformatf("d%0d r_addr", k), ra, exp_ra);
    check($sformatf("d%0d overflow", k), ov, m_ovf[k]);
    check($sformatf("d%0d underflow", k), un, m_unf[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
    wr_i = '0;
    rd_i = '0;
    clr_i = '0;
  endtask

  task automatic op(int k, bit w, bit r, bit c);
    wr_i[k] = w;
    rd_i[k] = r;
    clr_i[k] = c;
    tick();
  endtask

  initial begin
    model_reset();
    #2;
    check_dut(0);
    check_dut(1);
    check("reset empty", int'(bw.empty), 1);
    check("reset almost_empty", int'(bw.almost_empty), 1);
    #1 reset_n = 1'b1;

    phase = "fill";
    repeat (4) op(0, 1'b1, 1'b0, 1'b0);
    check("fill count", int'(bw.count), 8);
    check("fill full", int'(bw.full), 1);
    check("fill almost_full", int'(bw.almost_full), 1);
    op(0, 1'b1, 1'b0, 1'b0);
    check("overfill w_addr", int'(bw.w_addr), 0);
    check("overfill overflow", int'(bw.overflow), ERR_EN);

    phase = "drain";
    for (int i = 0; i < 8; i++) begin
      check("drain r_addr step", int'(bw.r_addr), i);
      op(0, 1'b0, 1'b1, 1'b0);
    end
    check("drain count", int'(bw.count), 0);
    check("drain empty", int'(bw.empty), 1);
    op(0, 1'b0, 1'b1, 1'b0);
    check("underread r_addr", int'(bw.r_addr), 0);
    check("underread underflow", int'(bw.underflow), ERR_EN);
    op(0, 1'b0, 1'b0, 1'b1);
    check("clr overflow", int'(bw.overflow), 0);
    check("clr underflow", int'(bw.underflow), 0);

    phase = "partial";
    repeat (4) op(0, 1'b1, 1'b0, 1'b0);
    op(0, 1'b0, 1'b1, 1'b0);
    check("count7", int'(bw.count), 7);
    check("count7 full", int'(bw.full), 1);
    op(0, 1'b0, 1'b1, 1'b0);
    check("count6", int'(bw.count), 6);
    check("count6 full", int'(bw.full), 0);
    repeat (6) op(0, 1'b0, 1'b1, 1'b0);

    phase = "simul";
    op(0, 1'b1, 1'b1, 1'b0);
    check("simul at 0 count", int'(bw.count), 2);
    op(0, 1'b1, 1'b0, 1'b0);
    op(0, 1'b1, 1'b1, 1'b0);
    check("simul at 4 count", int'(bw.count), 5);

    phase = "narrow";
    op(1, 1'b1, 1'b0, 1'b0);
    check("narrow 1 count", int'(bn.count), 1);
    check("narrow 1 empty", int'(bn.empty), 1);
    op(1, 1'b1, 1'b0, 1'b0);
    check("narrow 2 empty", int'(bn.empty), 0);
    op(1, 1'b0, 1'b1, 1'b0);
    check("wide read count", int'(bn.count), 0);
    check("wide read r_addr", int'(bn.r_addr), 1);

    phase = "async_rst";
    op(1, 1'b1, 1'b0, 1'b0);
    wr_i = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    wr_i = '0;
    @(negedge clk);
    reset_n = 1'b1;

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        wr_i[k]  = ($urandom_range(0, 99) < 55);
        rd_i[k]  = ($urandom_range(0, 99) < 50);
        clr_i[k] = ($urandom_range(0, 19) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asym_fifo_ctrl.md
# asym_fifo_ctrl

Parametrised pointer/status controller for an asymmetric-width FIFO. The storage array is addressed in narrow-word units. One side (the wide side) moves 2^RATIO_LOG2 narrow words per access; the other side (the narrow side) moves one. The controller generalises the fixed 2:1 write-wide controller to any power-of-two ratio and either wide direction. It adds occupancy count, almost-full/almost-empty thresholds and exact free-space full detection, and it sits between the producer/consumer handshakes and the dual-port RAM.

## Interface
Parameters:
- ADDR_WIDTH, 3: log2 of depth D in narrow words.
- RATIO_LOG2, 1: log2 of ratio R; R narrow words per wide access; 1 ≤ RATIO_LOG2 < ADDR_WIDTH.
- WIDE_WR, 1: 1 = write side wide, read side narrow; 0 = write side narrow, read side wide.
- AF_LEVEL, D−R: almost_full threshold, in narrow words.
- AE_LEVEL, R: almost_empty threshold, in narrow words.

Ports:
- Clock and reset (decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  sole clock, rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  write request.
- rd  in  1  read request.
- clr_err  in  1  clears sticky error flags.
- w_addr  out  ADDR_WIDTH−RATIO_LOG2 if WIDE_WR, else ADDR_WIDTH  write address, in write-side word units.
- r_addr  out  ADDR_WIDTH if WIDE_WR, else ADDR_WIDTH−RATIO_LOG2  read address, in read-side word units.
- full  out  1  write would not fit.
- empty  out  1  read cannot be satisfied.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  ADDR_WIDTH+1  occupancy in narrow words, 0..D.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Pointers:
  - Internal wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide, in narrow units, and include a wrap bit.
  - The wide-side pointer steps by R and is always R-aligned.
  - The narrow-side pointer steps by 1.
- count = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Addresses:
  - Wide-side address = pointer[ADDR_WIDTH−1:RATIO_LOG2].
  - Narrow-side address = pointer[ADDR_WIDTH−1:0].
- Flags for WIDE_WR=1:
  - full = (D − count) < R.
  - empty = (count == 0).
- Flags for WIDE_WR=0:
  - full = (count == D).
  - empty = (count < R).
- Acceptance:
  - A write is accepted when wr && !full.
  - A read is accepted when rd && !empty.
  - Both are judged on the current registered state and are independent of each other.
- Simultaneous wr and rd:
  - Each request is accepted or rejected on its own, and both pointers may advance in the same cycle.
  - When empty, the read is rejected even though a write is accepted in that cycle; there is no bypass.
  - When full, the write is rejected even though a read is accepted.
- Rejected requests leave the pointers unchanged. They are not queued.
- Wrap-around: pointers roll over modulo 2^(ADDR_WIDTH+1); the wrap bit disambiguates full from empty.
- Reset values: all pointers 0, count 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, w_addr 0, r_addr 0.

## Timing
- Every output is a function of registered state only; there is no combinational path from wr, rd or clr_err to any output.
- An accepted access updates pointers, addresses, count and flags at the next rising clk edge; latency is one cycle.
- The address presented in the cycle of an accepted access is the location used by that access.
- Assertion of reset_n low asynchronously forces the reset values mid-operation, with any in-flight request dropped. Deassertion is synchronised externally.
- clr_err takes effect at the next edge. If an error event occurs in the same cycle as clr_err, the set wins.

## Configuration
- ASYM_FIFO_ERR_EN:
  - Defined: overflow and underflow are sticky registers. Each is set on a rejected wr or rd request respectively, and cleared by clr_err or reset.
  - Undefined: overflow and underflow are tied to 0, clr_err is ignored, and no error registers are built.

## Structure
- asym_fifo_pkg holds:
  - the mode constants WIDE_SIDE_WR = 1 and WIDE_SIDE_RD = 0;
  - a function for the step size of each side given WIDE_WR and RATIO_LOG2;
  - localparam helpers for D and R.
- One sub-module, fifo_ptr: a pointer register with parameter STEP_LOG2, a step-enable input, and an asynchronous active-low reset. It is instantiated once for write and once for read.

## Test plan
The bench uses ADDR_WIDTH=3 (D=8) and RATIO_LOG2=1 (R=2) throughout.
- Reset (WIDE_WR=1) -> count=0, empty=1, full=0, almost_empty=1, w_addr=0, r_addr=0.
- Four writes -> count=8, full=1, almost_full=1. Fifth write -> ignored, w_addr stays 0, overflow=1 (with ERR_EN defined).
- From full, eight reads -> r_addr steps 0..7, count reaches 0 and empty=1. Ninth read -> r_addr stays 0, underflow=1. clr_err -> both flags return to 0.
- Four writes then one read, giving count=7 -> full=1 (free space 1 < R). Next read -> count=6, full=0.
- Simultaneous wr and rd at count=0 -> write accepted, read rejected, count=2. Simultaneous wr and rd at count=4 -> count=5.
- WIDE_WR=0: first narrow write -> count=1, empty stays 1. Second write -> empty=0. Wide read -> count=0, r_addr=1. Assert reset_n low mid-write -> all outputs return to reset values without waiting for clk.
